traffic_display_driver: RTL and testbench
=========================================

Name: traffic_display_driver

Overview:
- Downstream consumer of the traffic countdown counter.
- Takes the two BCD countdown pairs (tens and units per direction) and the two 2-bit light codes.
- Drives a 4-digit, common-anode, time-multiplexed 7-segment display and two one-hot lamp sets.
- Runs on the fast board clock, not the 1 Hz counter clock. Applies a frame-coherent snapshot so digits never tear mid-scan.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot; must be at least 4.
- DEAD_CYC, 2: cycles at the start of each slot with all anodes off (anti-ghosting); must be less than SCAN_DIV.
- BLINK_FRAMES, 64: full scan frames per blink half-period; used only with TD_BLINK_EN.

Ports:
- clk  in  1  board clock.
- reset  in  1  synchronous, active-high reset.
- light_chuc1  in  4  direction-1 tens digit (BCD).
- light_dv1  in  4  direction-1 units digit (BCD).
- light_chuc2  in  4  direction-2 tens digit (BCD).
- light_dv2  in  4  direction-2 units digit (BCD).
- light1  in  2  direction-1 light code: 0=off, 1=red, 2=yellow, 3=green.
- light2  in  2  direction-2 light code, same encoding.
- an  out  4  digit anodes, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- lamp1  out  3  direction-1 lamps {red,yellow,green}, active-high.
- lamp2  out  3  direction-2 lamps, same layout.

Behaviour:
- Reset (synchronous, active-high; takes effect on the clk edge where reset=1):
  - an=4'hF, seg=7'h7F, lamp1=lamp2=0.
  - Prescaler=0, digit index=0, snapshot=0, load_pending=1.
- Prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- Digit mapping:
  - idx0 = dv1, anode an[0]
  - idx1 = chuc1, anode an[1]
  - idx2 = dv2, anode an[2]
  - idx3 = chuc2, anode an[3]
- Snapshot:
  - All six inputs are captured together into snapshot registers.
  - Capture happens on the cycle where the index wraps 3→0.
  - Capture also happens on the first non-reset cycle while load_pending=1; load_pending then clears.
  - Input changes mid-frame are not visible until the next frame.
- Outputs an/seg are registered, 1-cycle latency from prescaler/index state.
  - While prescaler < DEAD_CYC: an=4'hF, seg=7'h7F.
  - Otherwise: the selected anode is driven low and seg carries the decoded snapshot digit.
- Decode values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Any code 10..15 shows dash 7'h3F.
- Leading-zero blanking (always on): a tens digit equal to 0 shows blank (seg=7'h7F), with its anode still driven. Units digits are never blanked.
- Lamps:
  - Registered from the live light codes, not the snapshot; 1-cycle latency.
  - Mapping: code 0→3'b000, 1→3'b100, 2→3'b010, 3→3'b001.
- Reset mid-slot or mid-frame: full reinit on the next edge; the first displayed frame uses values captured via load_pending.

Optional Feature:
- Macro: TD_BLINK_EN.
- Defined:
  - A frame counter counts index wraps modulo BLINK_FRAMES and toggles a blink phase at each rollover. Reset sets phase=on and the counter to 0.
  - While the snapshot light code of a direction is 2 (yellow) and phase=off, both digits of that direction show blank, with anodes still scanned.
  - Lamps are unaffected.
- Not defined: no frame counter or phase register; digits are always shown per the rules above.

Test Plan:
- Reset, with SCAN_DIV=4, DEAD_CYC=1, inputs chuc1=2, dv1=0, chuc2=1, dv2=5, light1=1, light2=3:
  - Outputs stay an=F, seg=7F, lamps 0 during reset.
  - After release, the slot sequence is an=E/seg=40, D/24, B/12, 7/79.
  - Each slot is preceded by one dead cycle with an=F.
  - lamp1=100, lamp2=001.
- Leading-zero blanking: chuc1=0, dv1=7 → the an=D slot shows seg=7F; the an=E slot shows 78.
- Invalid BCD: dv2=12 → the an=B slot shows seg=3F.
- Snapshot coherence: change dv1 3→4 during idx2 → the current frame keeps 3; the next an=E slot shows 19.
- Reset mid-frame at idx2 → next edge an=F; scan restarts at idx0 with the values sampled on the first post-reset cycle.
- With TD_BLINK_EN, BLINK_FRAMES=2, light2=2: the direction-2 digits alternate between shown and blank every 2 frames; direction 1 is always shown; lamp2=010 constant.

Source files
------------

// File: rtl/traffic_display_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : traffic_display_driver
//  Purpose  : Scans a 4-digit common-anode 7-segment display from a
//             frame-coherent snapshot of two BCD countdown pairs and drives
//             two one-hot lamp sets from the live light codes.
//             Optional blinking of a direction's digits while its light is
//             yellow is enabled by defining TD_BLINK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_display_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD_CYC     = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] light_chuc1,
    input  logic [3:0] light_dv1,
    input  logic [3:0] light_chuc2,
    input  logic [3:0] light_dv2,
    input  logic [1:0] light1,
    input  logic [1:0] light2,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic [2:0] lamp1,
    output logic [2:0] lamp2
);

    localparam int              c_PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(SCAN_DIV - 1);
    localparam logic [c_PW-1:0] c_DEAD       = c_PW'(DEAD_CYC);
    localparam logic [6:0]      c_SEG_BLANK  = 7'h7F;
    localparam logic [6:0]      c_SEG_DASH   = 7'h3F;

    logic [c_PW-1:0] r_presc_q, w_presc_d;
    logic [1:0]      r_idx_q, w_idx_d;
    logic            r_load_pending_q;
    logic [3:0]      r_snap_c1_q, r_snap_d1_q, r_snap_c2_q, r_snap_d2_q;
    logic [3:0]      w_snap_c1_d, w_snap_d1_d, w_snap_c2_d, w_snap_d2_d;
    logic [1:0]      r_snap_l1_q, r_snap_l2_q, w_snap_l1_d, w_snap_l2_d;
    logic [3:0]      r_an_q, w_an_d;
    logic [6:0]      r_seg_q, w_seg_d;
    logic [2:0]      r_lamp1_q, r_lamp2_q, w_lamp1_d, w_lamp2_d;

    logic            w_presc_wrap, w_frame_wrap, w_capture;
    logic [3:0]      w_digit;
    logic            w_is_tens;
    logic [1:0]      w_dir_light;
    logic            w_phase_off;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'h40;
            4'd1:    f_decode = 7'h79;
            4'd2:    f_decode = 7'h24;
            4'd3:    f_decode = 7'h30;
            4'd4:    f_decode = 7'h19;
            4'd5:    f_decode = 7'h12;
            4'd6:    f_decode = 7'h02;
            4'd7:    f_decode = 7'h78;
            4'd8:    f_decode = 7'h00;
            4'd9:    f_decode = 7'h10;
            default: f_decode = c_SEG_DASH;
        endcase
    endfunction

    function automatic logic [2:0] f_lamp(input logic [1:0] code);
        case (code)
            2'd1:    f_lamp = 3'b100;
            2'd2:    f_lamp = 3'b010;
            2'd3:    f_lamp = 3'b001;
            default: f_lamp = 3'b000;
        endcase
    endfunction

    // Slot timing and frame-coherent snapshot capture
    always_comb begin
        w_presc_wrap = (r_presc_q == c_PRESC_LAST);
        w_frame_wrap = w_presc_wrap && (r_idx_q == 2'd3);
        w_presc_d    = w_presc_wrap ? '0 : r_presc_q + 1'b1;
        w_idx_d      = w_presc_wrap ? r_idx_q + 2'd1 : r_idx_q;
        w_capture    = w_frame_wrap || r_load_pending_q;
        w_snap_c1_d  = w_capture ? light_chuc1 : r_snap_c1_q;
        w_snap_d1_d  = w_capture ? light_dv1   : r_snap_d1_q;
        w_snap_c2_d  = w_capture ? light_chuc2 : r_snap_c2_q;
        w_snap_d2_d  = w_capture ? light_dv2   : r_snap_d2_q;
        w_snap_l1_d  = w_capture ? light1      : r_snap_l1_q;
        w_snap_l2_d  = w_capture ? light2      : r_snap_l2_q;
    end

`ifdef TD_BLINK_EN
    localparam int              c_FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_FW-1:0] c_FCNT_LAST  = c_FW'(BLINK_FRAMES - 1);

    logic [c_FW-1:0] r_fcnt_q, w_fcnt_d;
    logic            r_phase_q, w_phase_d;

    // Blink phase flips once every BLINK_FRAMES completed frames
    always_comb begin
        w_fcnt_d  = r_fcnt_q;
        w_phase_d = r_phase_q;
        if (w_frame_wrap) begin
            if (r_fcnt_q == c_FCNT_LAST) begin
                w_fcnt_d  = '0;
                w_phase_d = ~r_phase_q;
            end else begin
                w_fcnt_d  = r_fcnt_q + 1'b1;
            end
        end
    end

    // Blink state registers; phase starts in the "on" half
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fcnt_q  <= '0;
            r_phase_q <= 1'b1;
        end else begin
            r_fcnt_q  <= w_fcnt_d;
            r_phase_q <= w_phase_d;
        end
    end

    assign w_phase_off = ~r_phase_q;
`else
    logic w_unused_blink;
    assign w_unused_blink = (^{r_snap_l1_q, r_snap_l2_q}) ^ (BLINK_FRAMES > 0);
    assign w_phase_off    = 1'b0;
`endif

    // Digit selection, decode, blanking and lamp mapping for the output registers
    always_comb begin
        w_digit     = r_snap_d1_q;
        w_is_tens   = 1'b0;
        w_dir_light = r_snap_l1_q;
        case (r_idx_q)
            2'd0: begin w_digit = r_snap_d1_q; w_is_tens = 1'b0; w_dir_light = r_snap_l1_q; end
            2'd1: begin w_digit = r_snap_c1_q; w_is_tens = 1'b1; w_dir_light = r_snap_l1_q; end
            2'd2: begin w_digit = r_snap_d2_q; w_is_tens = 1'b0; w_dir_light = r_snap_l2_q; end
            default: begin w_digit = r_snap_c2_q; w_is_tens = 1'b1; w_dir_light = r_snap_l2_q; end
        endcase

        w_an_d  = 4'hF;
        w_seg_d = c_SEG_BLANK;
        if (r_presc_q >= c_DEAD) begin
            w_an_d = ~(4'b0001 << r_idx_q);
            if ((w_is_tens && (w_digit == 4'd0)) || (w_phase_off && (w_dir_light == 2'd2)))
                w_seg_d = c_SEG_BLANK;
            else
                w_seg_d = f_decode(w_digit);
        end

        w_lamp1_d = f_lamp(light1);
        w_lamp2_d = f_lamp(light2);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc_q        <= '0;
            r_idx_q          <= 2'd0;
            r_load_pending_q <= 1'b1;
            r_snap_c1_q      <= 4'd0;
            r_snap_d1_q      <= 4'd0;
            r_snap_c2_q      <= 4'd0;
            r_snap_d2_q      <= 4'd0;
            r_snap_l1_q      <= 2'd0;
            r_snap_l2_q      <= 2'd0;
            r_an_q           <= 4'hF;
            r_seg_q          <= c_SEG_BLANK;
            r_lamp1_q        <= 3'b000;
            r_lamp2_q        <= 3'b000;
        end else begin
            r_presc_q        <= w_presc_d;
            r_idx_q          <= w_idx_d;
            r_load_pending_q <= 1'b0;
            r_snap_c1_q      <= w_snap_c1_d;
            r_snap_d1_q      <= w_snap_d1_d;
            r_snap_c2_q      <= w_snap_c2_d;
            r_snap_d2_q      <= w_snap_d2_d;
            r_snap_l1_q      <= w_snap_l1_d;
            r_snap_l2_q      <= w_snap_l2_d;
            r_an_q           <= w_an_d;
            r_seg_q          <= w_seg_d;
            r_lamp1_q        <= w_lamp1_d;
            r_lamp2_q        <= w_lamp2_d;
        end
    end

    assign an    = r_an_q;
    assign seg   = r_seg_q;
    assign lamp1 = r_lamp1_q;
    assign lamp2 = r_lamp2_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_display_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_display_driver
//  Purpose  : Self-checking bench for traffic_display_driver (SCAN_DIV=4,
//             DEAD_CYC=1, BLINK_FRAMES=2). Blink checks build with TD_BLINK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_display_driver;

    localparam int SD    = 4;
    localparam int DC    = 1;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] light_chuc1 = 4'd0, light_dv1 = 4'd0, light_chuc2 = 4'd0, light_dv2 = 4'd0;
    logic [1:0] light1 = 2'd0, light2 = 2'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic [2:0] lamp1, lamp2;

    always #5 clk = ~clk;

    traffic_display_driver #(
        .SCAN_DIV    (SD),
        .DEAD_CYC    (DC),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .light_chuc1(light_chuc1),
        .light_dv1  (light_dv1),
        .light_chuc2(light_chuc2),
        .light_dv2  (light_dv2),
        .light1     (light1),
        .light2     (light2),
        .an         (an),
        .seg        (seg),
        .lamp1      (lamp1),
        .lamp2      (lamp2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (d > 4'd9) return 7'h3F;
        return tbl[d];
    endfunction

    function automatic logic [2:0] ref_lamp(input logic [1:0] c);
        logic [2:0] tbl [4] = '{3'b000, 3'b100, 3'b010, 3'b001};
        return tbl[c];
    endfunction

    // ---------------- reference model: absolute cycle count since reset ----
    bit         m_valid = 1'b0;
    bit         m_lp;
    int         m_s;
    logic [3:0] m_snap [4];   // by display slot: dv1, chuc1, dv2, chuc2
    logic [1:0] m_light [2];  // snapshot light code per direction
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic [2:0] e_l1, e_l2;

    task automatic model_step();
        int p, idx, fr;
        logic [3:0] a;
        if (reset) begin
            e_an = 4'hF; e_seg = 7'h7F; e_l1 = 3'b000; e_l2 = 3'b000;
            m_s = 0; m_lp = 1'b1; m_valid = 1'b1;
            for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
            m_light[0] = 2'd0; m_light[1] = 2'd0;
        end else if (m_valid) begin
            p   = m_s % SD;
            idx = (m_s / SD) % 4;
            fr  = m_s / FRAME;
            if (p < DC) begin
                e_an = 4'hF; e_seg = 7'h7F;
            end else begin
                a = 4'hF; a[idx] = 1'b0; e_an = a;
                if ((idx % 2 == 1) && (m_snap[idx] == 4'd0)) e_seg = 7'h7F;
                else e_seg = ref_seg(m_snap[idx]);
`ifdef TD_BLINK_EN
                if ((m_light[idx / 2] == 2'd2) && (((fr / BF) % 2) == 1)) e_seg = 7'h7F;
`endif
            end
            e_l1 = ref_lamp(light1);
            e_l2 = ref_lamp(light2);
            if (m_lp || ((m_s % FRAME) == FRAME - 1)) begin
                m_snap[0] = light_dv1; m_snap[1] = light_chuc1;
                m_snap[2] = light_dv2; m_snap[3] = light_chuc2;
                m_light[0] = light1;   m_light[1] = light2;
            end
            m_lp = 1'b0;
            m_s++;
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_an",    {28'd0, an},    {28'd0, e_an});
            chk("model_seg",   {25'd0, seg},   {25'd0, e_seg});
            chk("model_lamps", {26'd0, lamp1, lamp2}, {26'd0, e_l1, e_l2});
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic wait_an(input logic [3:0] a);
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an === a) begin ok = 1'b1; break; end
        end
        if (!ok) chk("wait_an_timeout", {28'd0, an}, {28'd0, a});
    endtask

    task automatic set_in(input logic [3:0] c1, d1, c2, d2, input logic [1:0] l1, l2);
        light_chuc1 = c1; light_dv1 = d1; light_chuc2 = c2; light_dv2 = d2;
        light1 = l1; light2 = l2;
    endtask

    typedef struct packed {
        logic [3:0]      c1, d1, c2, d2;
        logic [1:0]      l1, l2;
        logic [3:0][6:0] seg;      // [0]=an E, [1]=an D, [2]=an B, [3]=an 7
        logic [2:0]      lp1, lp2;
    } vec_t;

    vec_t       tv [4];
    logic [3:0] slot_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seq_seg [4] = '{7'h40, 7'h24, 7'h12, 7'h79};
    bit         skip;
    logic [6:0] exp_s;

    initial begin
        tv[0] = '{4'd2, 4'd0, 4'd1, 4'd5,  2'd1, 2'd3, {7'h79, 7'h12, 7'h24, 7'h40}, 3'b100, 3'b001};
        tv[1] = '{4'd0, 4'd7, 4'd9, 4'd8,  2'd2, 2'd0, {7'h10, 7'h00, 7'h7F, 7'h78}, 3'b010, 3'b000};
        tv[2] = '{4'd3, 4'd6, 4'd0, 4'd12, 2'd3, 2'd1, {7'h7F, 7'h3F, 7'h30, 7'h02}, 3'b001, 3'b100};
        tv[3] = '{4'd4, 4'd9, 4'd15, 4'd1, 2'd0, 2'd2, {7'h3F, 7'h79, 7'h19, 7'h10}, 3'b000, 3'b010};

        // Reset state and the first frame after release
        set_in(4'd2, 4'd0, 4'd1, 4'd5, 2'd1, 2'd3);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_an",  {28'd0, an},  32'hF);
            chk("reset_seg", {25'd0, seg}, 32'h7F);
            chk("reset_lamps", {26'd0, lamp1, lamp2}, 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if ((i % SD) == 0) begin
                chk("first_frame_dead_an", {28'd0, an}, 32'hF);
                chk("first_frame_dead_seg", {25'd0, seg}, 32'h7F);
            end else begin
                chk("first_frame_an",  {28'd0, an},  {28'd0, slot_an[i / SD]});
                chk("first_frame_seg", {25'd0, seg}, {25'd0, seq_seg[i / SD]});
            end
        end
        chk("first_lamp1", {29'd0, lamp1}, 32'b100);
        chk("first_lamp2", {29'd0, lamp2}, 32'b001);

        // Table-driven vectors: decode, blanking, dash, lamps
        for (int v = 0; v < 4; v++) begin
            set_in(tv[v].c1, tv[v].d1, tv[v].c2, tv[v].d2, tv[v].l1, tv[v].l2);
            repeat (2 * FRAME + 2) @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                wait_an(slot_an[j]);
                skip = 1'b0;
`ifdef TD_BLINK_EN
                skip = (j < 2) ? (tv[v].l1 == 2'd2) : (tv[v].l2 == 2'd2);
`endif
                if (!skip) chk("table_seg", {25'd0, seg}, {25'd0, tv[v].seg[j]});
            end
            chk("table_lamp1", {29'd0, lamp1}, {29'd0, tv[v].lp1});
            chk("table_lamp2", {29'd0, lamp2}, {29'd0, tv[v].lp2});
        end

        // Snapshot coherence: mid-slot change held, next frame picks it up
        set_in(4'd1, 4'd3, 4'd2, 4'd4, 2'd3, 2'd1);
        repeat (2 * FRAME + 2) @(negedge clk);
        wait_an(4'hE);
        chk("coh_before", {25'd0, seg}, 32'h30);
        light_dv1 = 4'd4;
        @(negedge clk);
        chk("coh_hold_an",  {28'd0, an},  32'hE);
        chk("coh_hold_seg", {25'd0, seg}, 32'h30);
        wait_an(4'hB);
        wait_an(4'hE);
        chk("coh_next_frame", {25'd0, seg}, 32'h19);
        wait_an(4'hB);
        light_dv1 = 4'd5;
        wait_an(4'hE);
        chk("coh_idx2_change", {25'd0, seg}, 32'h12);

        // Reset in the middle of the frame
        wait_an(4'hB);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_an",  {28'd0, an},  32'hF);
        chk("midreset_seg", {25'd0, seg}, 32'h7F);
        light_dv1 = 4'd8;
        reset = 1'b0;
        @(negedge clk);
        chk("postreset_dead_an", {28'd0, an}, 32'hF);
        @(negedge clk);
        chk("postreset_an",  {28'd0, an},  32'hE);
        chk("postreset_seg", {25'd0, seg}, 32'h00);

`ifdef TD_BLINK_EN
        // Yellow direction 2 blinks every BF frames; direction 1 steady
        set_in(4'd4, 4'd1, 4'd3, 4'd6, 2'd3, 2'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int f = 0; f < 6; f++) begin
            wait_an(4'hB);
            exp_s = (((f / BF) % 2) == 1) ? 7'h7F : 7'h02;
            chk("blink_dv2", {25'd0, seg}, {25'd0, exp_s});
            wait_an(4'h7);
            exp_s = (((f / BF) % 2) == 1) ? 7'h7F : 7'h30;
            chk("blink_chuc2", {25'd0, seg}, {25'd0, exp_s});
            wait_an(4'hE);
            chk("blink_dir1", {25'd0, seg}, 32'h79);
            chk("blink_lamp2", {29'd0, lamp2}, 32'b010);
        end
`endif

        // Randomized traffic, occasional resets, checked by the model
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)
                set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       2'($urandom_range(0, 3)),  2'($urandom_range(0, 3)));
            reset = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (FRAME) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
